mac_pipe: RTL and testbench

Parametrised, pipelined integer multiply-accumulate unit. It is the next generation of the single-cycle 16-bit `a*b+c` MAC in the PIM datapath. It adds configurable width, signed arithmetic, an internal accumulator with four operation modes, wrap-or-saturate result reduction with an overflow flag, and valid/ready handshakes on both sides. It sits between the PIM operand fetch and the result write-back path.

---
 rtl/mac_pkg.sv | 20 ++
 rtl/mac_sat.sv | 37 +++
 rtl/mac_pipe.sv | 125 ++++++++++++
 tb/tb_mac_pipe.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types for the pipelined multiply-accumulate unit.
// Payload fields are sized for the widest supported WIDTH; narrower instances use the low bits.
package mac_pkg;

  localparam int unsigned MAC_MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    MAC_MODE_MAC   = 2'b00,
    MAC_MODE_ACC   = 2'b01,
    MAC_MODE_LOAD  = 2'b10,
    MAC_MODE_CLEAR = 2'b11
  } mac_mode_t;

  typedef struct packed {
    logic [2*MAC_MAX_WIDTH-1:0] product;
    logic [MAC_MAX_WIDTH-1:0]   c;
    mac_mode_t                  mode;
  } mac_s1_t;

endpackage

// File: rtl/mac_sat.sv
// Reduces the (2*WIDTH+1)-bit full result to WIDTH bits by truncation or clamping,
// flagging any value that does not survive the reduction.
module mac_sat #(
  parameter int unsigned WIDTH    = 16,
  parameter bit          SIGNED   = 1'b0,
  parameter bit          SATURATE = 1'b0
) (
  input  logic [2*WIDTH:0]  full_i,
  output logic [WIDTH-1:0]  result_o,
  output logic              sat_o
);

  localparam int unsigned FW = 2 * WIDTH + 1;

  logic fits;

  always_comb begin
    // In range when every bit above the result's sign/MSB is pure extension.
    if (SIGNED) begin
      fits = (full_i[FW-1:WIDTH-1] == {(WIDTH + 2){full_i[FW-1]}});
    end else begin
      fits = (full_i[FW-1:WIDTH] == '0);
    end
    sat_o    = !fits;
    result_o = full_i[WIDTH-1:0];
    if (SATURATE && !fits) begin
      if (!SIGNED) begin
        result_o = '1;
      end else if (full_i[FW-1]) begin
        result_o = {1'b1, {(WIDTH - 1){1'b0}}};
      end else begin
        result_o = {1'b0, {(WIDTH - 1){1'b1}}};
      end
    end
  end

endmodule

// File: rtl/mac_pipe.sv
// Two-stage pipelined multiply-accumulate with valid/ready handshakes on both sides.
// S1 holds the product and operands; S2 holds the reduced result and updates the accumulator.
module mac_pipe
  import mac_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter bit          SIGNED   = 1'b0,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_a,
  input  logic [WIDTH-1:0] io_b,
  input  logic [WIDTH-1:0] io_c,
  input  logic [1:0]       io_mode,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out,
  output logic             io_out_sat
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned FW = PW + 1;

  logic             s1_valid_q, s1_valid_d;
  logic             s2_valid_q, s2_valid_d;
  mac_s1_t          s1_q, s1_d;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] out_q;
  logic             sat_q;

  logic s1_ready, s2_ready, in_fire, s1_adv;

  assign s2_ready    = !s2_valid_q || io_out_ready;
  assign s1_ready    = !s1_valid_q || s2_ready;
  assign in_fire     = io_in_valid && s1_ready;
  assign s1_adv      = s1_valid_q && s2_ready;
  assign io_in_ready = s1_ready;

  // Stage 1: full-precision product; low PW bits of the extended product are exact either way.
  logic [PW-1:0] a_ext, b_ext, prod;

  assign a_ext = {{WIDTH{SIGNED & io_a[WIDTH-1]}}, io_a};
  assign b_ext = {{WIDTH{SIGNED & io_b[WIDTH-1]}}, io_b};
  assign prod  = a_ext * b_ext;

  always_comb begin
    s1_d                  = '0;
    s1_d.product[PW-1:0]  = prod;
    s1_d.c[WIDTH-1:0]     = io_c;
    s1_d.mode             = mac_mode_t'(io_mode);
  end

  // Stage 2: form the full sum and reduce it.
  logic [PW-1:0]    p;
  logic [WIDTH-1:0] cv;
  logic [FW-1:0]    p_ext, c_ext, acc_ext, full;
  logic [WIDTH-1:0] red;
  logic             red_sat;

  assign p       = s1_q.product[PW-1:0];
  assign cv      = s1_q.c[WIDTH-1:0];
  assign p_ext   = {SIGNED & p[PW-1], p};
  assign c_ext   = {{(WIDTH + 1){SIGNED & cv[WIDTH-1]}}, cv};
  assign acc_ext = {{(WIDTH + 1){SIGNED & acc_q[WIDTH-1]}}, acc_q};

  always_comb begin
    full = '0;
    unique case (s1_q.mode)
      MAC_MODE_MAC:   full = p_ext + c_ext;
      MAC_MODE_ACC:   full = acc_ext + p_ext;
      MAC_MODE_LOAD:  full = c_ext;
      MAC_MODE_CLEAR: full = '0;
    endcase
  end

  mac_sat #(
    .WIDTH    (WIDTH),
    .SIGNED   (SIGNED),
    .SATURATE (SATURATE)
  ) u_sat (
    .full_i   (full),
    .result_o (red),
    .sat_o    (red_sat)
  );

  // A stage refills whenever it is empty or its contents move on.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (s1_ready) s1_valid_d = io_in_valid;
    if (s2_ready) s2_valid_d = s1_valid_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      acc_q      <= '0;
      out_q      <= '0;
      sat_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (in_fire) s1_q <= s1_d;
      if (s1_adv) begin
        acc_q <= red;
        out_q <= red;
        sat_q <= red_sat;
      end
    end
  end

  assign io_out_valid = s2_valid_q;
  assign io_out       = out_q;
  assign io_out_sat   = sat_q;

  // Upper payload bits exist only for wider instances.
  logic unused_s1;
  assign unused_s1 = ^s1_q;

endmodule

// File: tb/tb_mac_pipe.sv
// Directed bench for mac_pipe: an unsigned wrapping instance and a signed saturating
// instance share one input stream; results are captured on output transfers.
module tb_mac_pipe;
  import mac_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] a = '0, b = '0, c = '0;
  logic [1:0]  mode = '0;

  logic        u_in_ready, u_valid, u_sat;
  logic [15:0] u_out;
  logic        s_in_ready, s_valid, s_sat;
  logic [15:0] s_out;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_acc = 0;

  logic [15:0] q_val_u[$], q_val_s[$];
  logic        q_sat_u[$], q_sat_s[$];
  int          q_cyc[$];

  mac_pipe #(.WIDTH(16), .SIGNED(1'b0), .SATURATE(1'b0)) dut_u (
    .clock(clock), .reset_n(reset_n), .io_in_valid(in_valid), .io_in_ready(u_in_ready),
    .io_a(a), .io_b(b), .io_c(c), .io_mode(mode), .io_out_valid(u_valid),
    .io_out_ready(out_ready), .io_out(u_out), .io_out_sat(u_sat)
  );

  mac_pipe #(.WIDTH(16), .SIGNED(1'b1), .SATURATE(1'b1)) dut_s (
    .clock(clock), .reset_n(reset_n), .io_in_valid(in_valid), .io_in_ready(s_in_ready),
    .io_a(a), .io_b(b), .io_c(c), .io_mode(mode), .io_out_valid(s_valid),
    .io_out_ready(out_ready), .io_out(s_out), .io_out_sat(s_sat)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Record every output transfer that the next rising edge will complete.
  always @(negedge clock) begin
    if (reset_n && out_ready) begin
      if (u_valid) begin
        q_val_u.push_back(u_out);
        q_sat_u.push_back(u_sat);
        q_cyc.push_back(cyc);
      end
      if (s_valid) begin
        q_val_s.push_back(s_out);
        q_sat_s.push_back(s_sat);
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [1:0] m, input logic [15:0] va, input logic [15:0] vb,
                      input logic [15:0] vc);
    logic ok;
    int   waited;
    ok = 1'b0;
    waited = 0;
    mode = m; a = va; b = vb; c = vc;
    in_valid = 1'b1;
    while (!ok && waited < 50) begin
      @(negedge clock);
      ok = u_in_ready;
      @(posedge clock);
      #1;
      waited++;
    end
    in_valid = 1'b0;
    check_eq("push accepted", ok, 1);
  endtask

  task automatic drain();
    repeat (4) @(posedge clock);
    #1;
  endtask

  task automatic expect_q(input string tag, input logic [15:0] eu, input logic esu,
                          input logic [15:0] es, input logic ess, output int t);
    logic avail;
    t = -1;
    avail = (q_val_u.size() > 0) && (q_val_s.size() > 0);
    check_eq({tag, " avail"}, avail, 1);
    if (avail) begin
      check_eq({tag, " u.out"}, q_val_u.pop_front(), eu);
      check_eq({tag, " u.sat"}, q_sat_u.pop_front(), esu);
      check_eq({tag, " s.out"}, q_val_s.pop_front(), es);
      check_eq({tag, " s.sat"}, q_sat_s.pop_front(), ess);
      t = q_cyc.pop_front();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int t0, t1, t2, t3;

    // Reset values while held in reset.
    #12;
    check_eq("rst valid", u_valid, 0);
    check_eq("rst out", u_out, 0);
    check_eq("rst sat", u_sat, 0);
    check_eq("rst in_ready", u_in_ready, 1);
    check_eq("rst s in_ready", s_in_ready, 1);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Reset mid-stream discards the in-flight op and clears acc.
    push(MAC_MODE_MAC, 16'd3, 16'd4, 16'd5);
    @(posedge clock);
    #1;
    check_eq("pre-rst valid", u_valid, 1);
    #1;
    reset_n = 1'b0;
    #1;
    check_eq("midrst valid", u_valid, 0);
    check_eq("midrst out", u_out, 0);
    check_eq("midrst sat", u_sat, 0);
    check_eq("midrst in_ready", u_in_ready, 1);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check_eq("midrst no output", q_val_u.size(), 0);
    push(MAC_MODE_ACC, 16'd1, 16'd1, 16'd0);
    drain();
    expect_q("post-rst acc", 16'h0001, 0, 16'h0001, 0, t0);

    // MAC wrap with latency check.
    push(MAC_MODE_MAC, 16'h0100, 16'h0100, 16'h0005);
    check_eq("lat k valid", u_valid, 0);
    @(posedge clock);
    #1;
    check_eq("lat k+1 valid", u_valid, 1);
    drain();
    expect_q("mac wrap", 16'h0005, 1, 16'h7FFF, 1, t0);
    push(MAC_MODE_MAC, 16'd3, 16'd4, 16'd5);
    drain();
    expect_q("mac small", 16'h0011, 0, 16'h0011, 0, t0);

    // LOAD then back-to-back ACCs.
    push(MAC_MODE_LOAD, 16'd0, 16'd0, 16'd10);
    push(MAC_MODE_ACC, 16'd3, 16'd4, 16'd0);
    push(MAC_MODE_ACC, 16'd3, 16'd4, 16'd0);
    push(MAC_MODE_ACC, 16'd3, 16'd4, 16'd0);
    drain();
    expect_q("chain load", 16'd10, 0, 16'd10, 0, t0);
    expect_q("chain acc1", 16'd22, 0, 16'd22, 0, t1);
    expect_q("chain acc2", 16'd34, 0, 16'd34, 0, t2);
    check_eq("chain gap1", t1 - t0, 1);
    check_eq("chain gap2", t2 - t1, 1);
    expect_q("chain acc3", 16'd46, 0, 16'd46, 0, t3);
    check_eq("chain gap3", t3 - t2, 1);

    // Saturation boundaries (signed instance clamps, unsigned instance wraps).
    push(MAC_MODE_MAC, 16'h7FFF, 16'h7FFF, 16'h0000);
    push(MAC_MODE_MAC, 16'h8000, 16'h7FFF, 16'h0000);
    push(MAC_MODE_MAC, 16'hFFFF, 16'h0002, 16'h0001);
    drain();
    expect_q("sat max", 16'h0001, 1, 16'h7FFF, 1, t0);
    expect_q("sat min", 16'h8000, 1, 16'h8000, 1, t0);
    expect_q("sat neg1", 16'hFFFF, 1, 16'hFFFF, 0, t0);

    // Back-pressure: two beats fill the pipe, output held for five cycles.
    out_ready = 1'b0;
    n_acc = 0;
    fork
      begin
        for (int j = 0; j < 4; j++) begin
          push(MAC_MODE_MAC, 16'(j + 1), 16'd2, 16'(j));
          n_acc++;
        end
      end
      begin
        repeat (2) @(posedge clock);
        #2;
        check_eq("bp accepts", n_acc, 2);
        check_eq("bp in_ready", u_in_ready, 0);
        check_eq("bp valid", u_valid, 1);
        check_eq("bp out", u_out, 16'd2);
        repeat (3) @(posedge clock);
        #2;
        check_eq("bp accepts late", n_acc, 2);
        check_eq("bp in_ready late", u_in_ready, 0);
        check_eq("bp out held", u_out, 16'd2);
        check_eq("bp s out held", s_out, 16'd2);
        out_ready = 1'b1;
      end
    join
    drain();
    expect_q("bp r0", 16'd2, 0, 16'd2, 0, t0);
    expect_q("bp r1", 16'd5, 0, 16'd5, 0, t0);
    expect_q("bp r2", 16'd8, 0, 16'd8, 0, t0);
    expect_q("bp r3", 16'd11, 0, 16'd11, 0, t0);
    check_eq("bp no extra", q_val_u.size(), 0);

    // CLEAR between accumulations.
    push(MAC_MODE_CLEAR, 16'd0, 16'd0, 16'd0);
    push(MAC_MODE_ACC, 16'd2, 16'd2, 16'd0);
    push(MAC_MODE_CLEAR, 16'd0, 16'd0, 16'd0);
    push(MAC_MODE_ACC, 16'd1, 16'd1, 16'd0);
    drain();
    expect_q("clr first", 16'd0, 0, 16'd0, 0, t0);
    expect_q("clr acc4", 16'd4, 0, 16'd4, 0, t0);
    expect_q("clr zero", 16'd0, 0, 16'd0, 0, t0);
    expect_q("clr acc1", 16'd1, 0, 16'd1, 0, t0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
